// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, immediate format encoding and the
// occupancy states of the decode skid buffer.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder: classifies the format from the opcode
// and sign-extends the gathered immediate from instr[31] out to XLEN bits.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SUPPORT_UJ = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  imm_fmt_e    fmt_e;

  // Build a 32-bit immediate whose MSB is already the sign; widening happens once below.
  always_comb begin
    imm32   = '0;
    fmt_e   = FMT_ILL;
    illegal = 1'b1;
    case (instr[6:0])
      OP_R: begin
        fmt_e   = FMT_R;
        illegal = 1'b0;
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt_e   = FMT_I;
        illegal = 1'b0;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt_e   = FMT_S;
        illegal = 1'b0;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt_e   = FMT_B;
        illegal = 1'b0;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        if (SUPPORT_UJ != 0) begin
          fmt_e   = FMT_U;
          illegal = 1'b0;
          imm32   = {instr[31:12], 12'b0};
        end
      end
      OP_JAL: begin
        if (SUPPORT_UJ != 0) begin
          fmt_e   = FMT_J;
          illegal = 1'b0;
          imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
      end
      default: ;
    endcase
  end

  assign fmt = fmt_e;
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes on accept, holds results in a two-entry
// skid buffer behind valid/ready, and counts accepted illegal opcodes.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SUPPORT_UJ = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] illegal_count,
  input  logic             clear_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  imm_decode #(
    .XLEN       (XLEN),
    .SUPPORT_UJ (SUPPORT_UJ)
  ) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  buf_state_e      state, state_next;
  logic            in_ready_q;
  logic            accept, deliver;
  logic            load_main, load_skid, skid_to_main;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [2:0]      main_fmt, skid_fmt;
  logic            main_illegal, skid_illegal;
  logic [31:0]     main_instr, skid_instr;
  logic [CNT_W-1:0] count;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != BUF_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign deliver   = out_valid && out_ready;

  // Occupancy transitions; FULL never sees an accept because in_ready is low there.
  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          state_next = BUF_ONE;
          load_main  = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && deliver) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_next = BUF_FULL;
          load_skid  = 1'b1;
        end else if (deliver) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (deliver) begin
          state_next   = BUF_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  // in_ready follows the next occupancy so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BUF_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != BUF_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm     <= '0;
      main_fmt     <= '0;
      main_illegal <= 1'b0;
      main_instr   <= '0;
      skid_imm     <= '0;
      skid_fmt     <= '0;
      skid_illegal <= 1'b0;
      skid_instr   <= '0;
    end else begin
      if (load_main) begin
        main_imm     <= dec_imm;
        main_fmt     <= dec_fmt;
        main_illegal <= dec_illegal;
        main_instr   <= in_instr;
      end else if (skid_to_main) begin
        main_imm     <= skid_imm;
        main_fmt     <= skid_fmt;
        main_illegal <= skid_illegal;
        main_instr   <= skid_instr;
      end
      if (load_skid) begin
        skid_imm     <= dec_imm;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
        skid_instr   <= in_instr;
      end
    end
  end

  // Counted on accept; a clear in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear_count) begin
      count <= '0;
    end else if (accept && dec_illegal && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign out_imm       = main_imm;
  assign out_fmt       = main_fmt;
  assign out_illegal   = main_illegal;
  assign out_instr     = main_instr;
  assign illegal_count = count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: three parameterisations share one stimulus
// stream, checked by hand vectors, corner sequences and a scoreboarded random run.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        clear_count;
  logic [31:0] in_instr;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a, out_instr_a;
  logic [2:0]  out_fmt_a;
  logic [7:0]  cnt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [31:0] out_instr_b;
  logic [2:0]  out_fmt_b;
  logic [1:0]  cnt_b;

  logic        in_ready_c, out_valid_c, out_illegal_c;
  logic [63:0] out_imm_c;
  logic [31:0] out_instr_c;
  logic [2:0]  out_fmt_c;
  logic [7:0]  cnt_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SUPPORT_UJ(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
    .out_instr(out_instr_a), .illegal_count(cnt_a), .clear_count(clear_count)
  );

  imm_gen_pipe #(.XLEN(64), .SUPPORT_UJ(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
    .out_instr(out_instr_b), .illegal_count(cnt_b), .clear_count(clear_count)
  );

  imm_gen_pipe #(.XLEN(64), .SUPPORT_UJ(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_instr(in_instr), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_imm(out_imm_c), .out_fmt(out_fmt_c), .out_illegal(out_illegal_c),
    .out_instr(out_instr_c), .illegal_count(cnt_c), .clear_count(clear_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ref_t;

  localparam longint TWO31 = 64'sd2147483648;
  localparam longint TWO32 = 64'sd4294967296;

  // Reference decode from the ISA field layout, using signed integer arithmetic.
  function automatic ref_t ref_decode(input logic [31:0] ins, input bit uj);
    ref_t   r;
    longint v;
    v     = 0;
    r.fmt = 3'd7;
    r.ill = 1'b1;
    case (ins[6:0])
      7'h33: begin r.fmt = 3'd0; r.ill = 1'b0; end
      7'h13, 7'h03, 7'h67, 7'h73: begin
        r.fmt = 3'd1; r.ill = 1'b0;
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'h23: begin
        r.fmt = 3'd2; r.ill = 1'b0;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        r.fmt = 3'd3; r.ill = 1'b0;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h37, 7'h17: begin
        if (uj) begin
          r.fmt = 3'd4; r.ill = 1'b0;
          v = longint'(ins[31:12]) * 4096;
          if (v >= TWO31) v = v - TWO32;
        end
      end
      7'h6F: begin
        if (uj) begin
          r.fmt = 3'd5; r.ill = 1'b0;
          v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
          if (v >= 1048576) v = v - 2097152;
        end
      end
      default: ;
    endcase
    r.imm = v;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    clear_count = 1'b0;
    in_instr    = '0;
    rst_n       = 1'b0;
    step();
    step();
    check_output("rst_in_ready", in_ready_a, 0);
    check_output("rst_out_valid", out_valid_a, 0);
    check_output("rst_imm", out_imm_a, 0);
    check_output("rst_fmt", out_fmt_a, 0);
    check_output("rst_illegal", out_illegal_a, 0);
    check_output("rst_instr", out_instr_a, 0);
    check_output("rst_count_a", cnt_a, 0);
    check_output("rst_count_b", cnt_b, 0);
    rst_n = 1'b1;
    step();
    check_output("post_rst_in_ready", in_ready_a, 1);
    check_output("post_rst_out_valid", out_valid_a, 0);
  endtask

  // Random-phase scoreboard state
  logic [31:0] sb_q[$];
  int          cnt_m[3];

  task automatic compare_all();
    ref_t ra, rb;
    int   n;
    n = sb_q.size();
    check_output("rnd_valid_a", out_valid_a, (n > 0) ? 1 : 0);
    check_output("rnd_valid_b", out_valid_b, (n > 0) ? 1 : 0);
    check_output("rnd_valid_c", out_valid_c, (n > 0) ? 1 : 0);
    check_output("rnd_ready_a", in_ready_a, (n < 2) ? 1 : 0);
    check_output("rnd_ready_b", in_ready_b, (n < 2) ? 1 : 0);
    check_output("rnd_ready_c", in_ready_c, (n < 2) ? 1 : 0);
    check_output("rnd_cnt_a", cnt_a, cnt_m[0]);
    check_output("rnd_cnt_b", cnt_b, cnt_m[1]);
    check_output("rnd_cnt_c", cnt_c, cnt_m[2]);
    if (n > 0) begin
      ra = ref_decode(sb_q[0], 1'b1);
      rb = ref_decode(sb_q[0], 1'b0);
      check_output("rnd_imm_a", out_imm_a, {32'd0, ra.imm[31:0]});
      check_output("rnd_fmt_a", out_fmt_a, ra.fmt);
      check_output("rnd_ill_a", out_illegal_a, ra.ill);
      check_output("rnd_instr_a", out_instr_a, sb_q[0]);
      check_output("rnd_imm_b", out_imm_b, rb.imm);
      check_output("rnd_fmt_b", out_fmt_b, rb.fmt);
      check_output("rnd_ill_b", out_illegal_b, rb.ill);
      check_output("rnd_instr_b", out_instr_b, sb_q[0]);
      check_output("rnd_imm_c", out_imm_c, ra.imm);
      check_output("rnd_fmt_c", out_fmt_c, ra.fmt);
      check_output("rnd_ill_c", out_illegal_c, ra.ill);
      check_output("rnd_instr_c", out_instr_c, sb_q[0]);
    end
  endtask

  task automatic apply_stimulus_random(input int cycles);
    logic [6:0]  op_list[12];
    logic [31:0] r;
    int          idx;
    bit          acc, del;
    int          maxv[3];
    bit          illv[3];
    op_list = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h00, 7'h7F};
    maxv = '{255, 3, 255};
    for (int cyc = 0; cyc < cycles; cyc++) begin
      r   = $urandom();
      idx = $urandom_range(0, 12);
      if (idx == 12) in_instr = r;
      else in_instr = {r[31:7], op_list[idx]};
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      clear_count = ($urandom_range(0, 19) == 0);
      compare_all();
      acc = in_valid && (sb_q.size() < 2);
      del = out_ready && (sb_q.size() > 0);
      illv[0] = ref_decode(in_instr, 1'b1).ill;
      illv[1] = ref_decode(in_instr, 1'b0).ill;
      illv[2] = illv[0];
      step();
      if (del) void'(sb_q.pop_front());
      if (acc) sb_q.push_back(in_instr);
      for (int k = 0; k < 3; k++) begin
        if (clear_count) cnt_m[k] = 0;
        else if (acc && illv[k] && cnt_m[k] < maxv[k]) cnt_m[k]++;
      end
    end
    in_valid    = 1'b0;
    clear_count = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[15];
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
    vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h00000000, 3'd7, 1'b1};
    vecs[5]  = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0};
    vecs[6]  = '{32'h008000EF, 32'h00000008, 3'd5, 1'b0};
    vecs[7]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0};
    vecs[8]  = '{32'h00412083, 32'h00000004, 3'd1, 1'b0};
    vecs[9]  = '{32'h00008067, 32'h00000000, 3'd1, 1'b0};
    vecs[10] = '{32'h00000073, 32'h00000000, 3'd1, 1'b0};
    vecs[11] = '{32'hFFFFF017, 32'hFFFFF000, 3'd4, 1'b0};
    vecs[12] = '{32'h00112223, 32'h00000004, 3'd2, 1'b0};
    vecs[13] = '{32'h00209463, 32'h00000008, 3'd3, 1'b0};
    vecs[14] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};

    rst_n = 1'b1;
    #2;
    apply_reset();

    // Back-to-back vectors with downstream always ready: one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      step();
      check_output("vec_valid", out_valid_a, 1);
      check_output("vec_imm", out_imm_a, vecs[i].imm);
      check_output("vec_fmt", out_fmt_a, vecs[i].fmt);
      check_output("vec_illegal", out_illegal_a, vecs[i].ill);
      check_output("vec_instr", out_instr_a, vecs[i].instr);
    end
    in_valid = 1'b0;
    step();
    check_output("vec_drain_valid", out_valid_a, 0);

    // Stall: two accepted, third held off, then drained in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    step();
    check_output("stall_valid0", out_valid_a, 1);
    check_output("stall_ready_one", in_ready_a, 1);
    in_instr = 32'h00200093;
    step();
    check_output("stall_ready_full", in_ready_a, 0);
    check_output("stall_imm_hold1", out_imm_a, 1);
    in_instr = 32'h00300093;
    step();
    check_output("stall_ready_full2", in_ready_a, 0);
    check_output("stall_imm_hold2", out_imm_a, 1);
    check_output("stall_instr_hold", out_instr_a, 32'h00100093);
    step();
    check_output("stall_imm_hold3", out_imm_a, 1);
    out_ready = 1'b1;
    step();
    check_output("drain_imm2", out_imm_a, 2);
    check_output("drain_ready", in_ready_a, 1);
    step();
    check_output("drain_imm3", out_imm_a, 3);
    check_output("drain_valid3", out_valid_a, 1);
    in_valid = 1'b0;
    step();
    check_output("drain_empty", out_valid_a, 0);

    // Saturating counter on the CNT_W=2 instance, then clear racing an illegal accept.
    apply_reset();
    out_ready = 1'b1;
    in_instr  = 32'h00000000;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_output("sat_illegal", out_illegal_b, 1);
      check_output("sat_fmt", out_fmt_b, 7);
      check_output("sat_imm", out_imm_b, 0);
      check_output("sat_count", cnt_b, (k + 1 > 3) ? 3 : k + 1);
    end
    check_output("sat_count_a", cnt_a, 5);
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    check_output("clear_wins_b", cnt_b, 0);
    check_output("clear_wins_a", cnt_a, 0);
    check_output("clear_out_illegal", out_illegal_b, 1);

    // LUI with the sign bit set: 64-bit extension and SUPPORT_UJ gating.
    in_instr = 32'h800000B7;
    step();
    check_output("uj0_fmt", out_fmt_b, 7);
    check_output("uj0_illegal", out_illegal_b, 1);
    check_output("uj0_imm", out_imm_b, 0);
    check_output("uj1_imm64", out_imm_c, 64'hFFFFFFFF80000000);
    check_output("uj1_fmt", out_fmt_c, 4);
    check_output("xlen32_imm", out_imm_a, 32'h80000000);
    check_output("uj0_count", cnt_b, 1);
    in_valid = 1'b0;
    step();

    // Reset while FULL discards both entries.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00000000;
    step();
    in_instr = 32'h0000007F;
    step();
    check_output("full_before_rst", in_ready_a, 0);
    check_output("full_count", cnt_a, 2);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_output("async_rst_valid", out_valid_a, 0);
    check_output("async_rst_count", cnt_a, 0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check_output("no_stale_valid", out_valid_a, 0);
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    step();
    check_output("after_rst_valid", out_valid_a, 1);
    check_output("after_rst_imm", out_imm_a, 1);
    check_output("after_rst_instr", out_instr_a, 32'h00100093);
    check_output("after_rst_count", cnt_a, 0);
    in_valid = 1'b0;
    step();
    check_output("after_rst_empty", out_valid_a, 0);

    // Randomised traffic against the queue model.
    apply_reset();
    sb_q.delete();
    cnt_m = '{0, 0, 0};
    apply_stimulus_random(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
